// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
// Used by shift_core and shift_arbiter.
package shift_arbiter_pkg;

    localparam int XLEN_DEF = 32;
    localparam int SHW_DEF  = 5;

    localparam logic REQ_EXU = 1'b0;
    localparam logic REQ_SEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_core.sv
// Combinational shifter: left, logical right or arithmetic right by shamt.
// Holds no state; the arbiter supplies operands and captures the result.
module shift_core
    import shift_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int SHW  = SHW_DEF
) (
    input  logic [XLEN-1:0] data,
    input  logic [SHW-1:0]  shamt,
    input  logic            l_or_r,
    input  logic            a_or_l,
    output logic [XLEN-1:0] result
);

    // NOTE: every path assigns result, so no latch is inferred.
    always_comb begin
        if (l_or_r) begin
            result = data << shamt;
        end else if (a_or_l) begin
            result = $unsigned($signed(data) >>> shamt);
        end else begin
            result = data >> shamt;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter feeding one shifter from two requesters (IDLE/RUN/DONE).
// Define SHIFT_ARBITER_ITER_EN for a one-bit-per-cycle shifter instead of a barrel shift.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int SHW  = SHW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [XLEN-1:0] req_data0,
    input  logic [XLEN-1:0] req_data1,
    input  logic [SHW-1:0]  req_shamt0,
    input  logic [SHW-1:0]  req_shamt1,
    input  logic            req_l_or_r0,
    input  logic            req_l_or_r1,
    input  logic            req_a_or_l0,
    input  logic            req_a_or_l1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_id
);

    state_t            state;
    state_t            state_next;
    logic              last;
    logic              grant;
    logic              accept;
    logic              run_done;
    logic [XLEN-1:0]   work;
    logic [SHW-1:0]    shamt_q;
    logic              l_or_r_q;
    logic              a_or_l_q;
    logic [XLEN-1:0]   shifted;

    // On a tie the requester not served last wins; a lone requester always wins.
    always_comb begin
        grant = REQ_EXU;
        if (req_valid == 2'b11) begin
            grant = ~last;
        end else if (req_valid[1]) begin
            grant = REQ_SEC;
        end
        accept    = (state == IDLE) && !rst && req_valid[grant];
        req_ready = 2'b00;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

`ifdef SHIFT_ARBITER_ITER_EN
    shift_core #(.XLEN(XLEN), .SHW(SHW)) u_core (
        .data   (work),
        .shamt  (SHW'(1)),
        .l_or_r (l_or_r_q),
        .a_or_l (a_or_l_q),
        .result (shifted)
    );
    assign run_done = (shamt_q <= SHW'(1));
`else
    shift_core #(.XLEN(XLEN), .SHW(SHW)) u_core (
        .data   (work),
        .shamt  (shamt_q),
        .l_or_r (l_or_r_q),
        .a_or_l (a_or_l_q),
        .result (shifted)
    );
    assign run_done = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (run_done)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    assign out_valid = (state == DONE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= REQ_SEC;
            out_id   <= REQ_EXU;
            out_data <= '0;
        end else begin
            if (accept) begin
                last   <= grant;
                out_id <= grant;
            end
            if (state == RUN && run_done) begin
`ifdef SHIFT_ARBITER_ITER_EN
                out_data <= (shamt_q == '0) ? work : shifted;
`else
                out_data <= shifted;
`endif
            end
        end
    end

    // NOTE: operand registers are never read before an accept loads them, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            work     <= grant ? req_data1   : req_data0;
            shamt_q  <= grant ? req_shamt1  : req_shamt0;
            l_or_r_q <= grant ? req_l_or_r1 : req_l_or_r0;
            a_or_l_q <= grant ? req_a_or_l1 : req_a_or_l0;
        end
`ifdef SHIFT_ARBITER_ITER_EN
        else if (state == RUN && !run_done) begin
            work    <= shifted;
            shamt_q <= shamt_q - SHW'(1);
        end
`endif
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: vector table, scoreboard and corner sequences.
// Latency expectations follow SHIFT_ARBITER_ITER_EN when it is defined.
module tb_shift_arbiter;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [XLEN-1:0] req_data0, req_data1;
    logic [SHW-1:0]  req_shamt0, req_shamt1;
    logic            req_l_or_r0, req_l_or_r1;
    logic            req_a_or_l0, req_a_or_l1;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic            out_id;

    shift_arbiter #(.XLEN(XLEN), .SHW(SHW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .req_shamt0  (req_shamt0),
        .req_shamt1  (req_shamt1),
        .req_l_or_r0 (req_l_or_r0),
        .req_l_or_r1 (req_l_or_r1),
        .req_a_or_l0 (req_a_or_l0),
        .req_a_or_l1 (req_a_or_l1),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_id      (out_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic        lr;
        logic        al;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        id;
    } sb_t;

    sb_t  sb[$];
    logic grant_log[$];
    int   accept_cyc[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Bit-by-bit reference shifter.
    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] sh,
                                          input logic lr, input logic al);
        logic [31:0] r;
        int s;
        s = int'(sh);
        for (int i = 0; i < 32; i++) begin
            if (lr) r[i] = (i >= s) ? d[i - s] : 1'b0;
            else    r[i] = (i + s < 32) ? d[i + s] : (al & d[31]);
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on request handshake, pop on result handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid[0] && req_ready[0]) begin
                sb.push_back('{model(req_data0, req_shamt0, req_l_or_r0, req_a_or_l0), 1'b0});
                grant_log.push_back(1'b0);
                accept_cyc.push_back(cyc);
            end
            if (req_valid[1] && req_ready[1]) begin
                sb.push_back('{model(req_data1, req_shamt1, req_l_or_r1, req_a_or_l1), 1'b1});
                grant_log.push_back(1'b1);
                accept_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_id", {31'b0, out_id}, {31'b0, e.id});
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        if (v.id) begin
            req_data1 = v.data; req_shamt1 = v.shamt; req_l_or_r1 = v.lr; req_a_or_l1 = v.al;
        end else begin
            req_data0 = v.data; req_shamt0 = v.shamt; req_l_or_r0 = v.lr; req_a_or_l0 = v.al;
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic issue(input vec_t v);
        logic ok;
        ok = 1'b0;
        drive(v);
        req_valid[v.id] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[v.id]) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_seen", {31'b0, ok}, 32'd1);
        @(posedge clk); #1;
        req_valid[v.id] = 1'b0;
        if (v.id) begin
            req_data1 = $urandom; req_shamt1 = 5'($urandom); req_l_or_r1 = ~v.lr; req_a_or_l1 = ~v.al;
        end else begin
            req_data0 = $urandom; req_shamt0 = 5'($urandom); req_l_or_r0 = ~v.lr; req_a_or_l0 = ~v.al;
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    function automatic int exp_latency(input logic [4:0] sh);
`ifdef SHIFT_ARBITER_ITER_EN
        return ((sh == 5'd0) ? 1 : int'(sh)) + 1;
`else
        return 2;
`endif
    endfunction

    vec_t vecs[12];

    initial begin
        int   lat;
        logic seen;
        logic [31:0] held;

        vecs[0]  = '{1'b0, 32'h0000_00F0, 5'd4,  1'b1, 1'b0, 32'h0000_0F00};
        vecs[1]  = '{1'b1, 32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, 32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001};
        vecs[3]  = '{1'b0, 32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 32'h1234_5678, 5'd8,  1'b0, 1'b0, 32'h0012_3456};
        vecs[7]  = '{1'b1, 32'hF000_0000, 5'd4,  1'b0, 1'b1, 32'hFF00_0000};
        vecs[8]  = '{1'b0, 32'h8000_0001, 5'd1,  1'b1, 1'b1, 32'h0000_0002};
        vecs[9]  = '{1'b1, 32'h7FFF_FFFF, 5'd31, 1'b0, 1'b1, 32'h0000_0000};
        vecs[10] = '{1'b0, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0, 32'h8000_0000};
        vecs[11] = '{1'b1, 32'h0000_0001, 5'd16, 1'b1, 1'b0, 32'h0001_0000};

        // Reset with both requesters already valid: nothing granted while rst is high.
        rst = 1'b1; out_ready = 1'b1; req_valid = 2'b11;
        req_data0 = 32'h0000_0011; req_shamt0 = 5'd1; req_l_or_r0 = 1'b1; req_a_or_l0 = 1'b0;
        req_data1 = 32'h8000_0000; req_shamt1 = 5'd1; req_l_or_r1 = 1'b0; req_a_or_l1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", {30'b0, req_ready}, 32'd0);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_out_id", {31'b0, out_id}, 32'd0);

        // Both valid continuously: grants alternate starting with requester 0.
        @(posedge clk); #1;
        rst = 1'b0;
        grant_log.delete(); accept_cyc.delete();
        for (int k = 0; k < 100 && grant_log.size() < 4; k++) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_out(lat);
        @(posedge clk); #1;
        check("rr_count", grant_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check($sformatf("rr_grant%0d", i), {31'b0, grant_log[i]}, (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i > 0) check($sformatf("rr_interval%0d", i), accept_cyc[i] - accept_cyc[i-1], 32'd3);
        end

        // Vector table.
        foreach (vecs[i]) begin
            issue(vecs[i]);
            wait_out(lat);
            check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
            check($sformatf("vec%0d_id", i), {31'b0, out_id}, {31'b0, vecs[i].id});
            check($sformatf("vec%0d_latency", i), lat, exp_latency(vecs[i].shamt));
            @(posedge clk); #1;
        end

        // Back-pressure in DONE with the other requester waiting.
        out_ready = 1'b0;
        issue('{1'b0, 32'h0000_ABCD, 5'd4, 1'b1, 1'b0, 32'h000A_BCD0});
        req_valid[1] = 1'b1;
        wait_out(lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            req_data1 = $urandom;
            @(negedge clk);
            check($sformatf("bp%0d_valid", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("bp%0d_data", k), out_data, 32'h000A_BCD0);
            check($sformatf("bp%0d_id", k), {31'b0, out_id}, 32'd0);
            check($sformatf("bp%0d_ready", k), {30'b0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        req_data1 = 32'h0000_0F0F; req_shamt1 = 5'd8; req_l_or_r1 = 1'b1; req_a_or_l1 = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("consume_cycle_ready", {30'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("after_consume_ready", {30'b0, req_ready}, 32'd2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_out(lat);
        check("bp_followup_data", out_data, 32'h000F_0F00);
        @(posedge clk); #1;

        // Reset while the operation is in RUN.
        issue('{1'b0, 32'h00F0_0000, 5'd20, 1'b0, 1'b0, 32'h0000_000F});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst_run_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_run_out_data", out_data, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("rst_run_no_pulse", {31'b0, seen}, 32'd0);
        @(posedge clk); #1;
        issue('{1'b1, 32'hDEAD_BEEF, 5'd4, 1'b0, 1'b1, 32'hFDEA_DBEE});
        wait_out(lat);
        held = out_data;
        check("rst_next_data", held, 32'hFDEA_DBEE);
        check("rst_next_id", {31'b0, out_id}, 32'd1);
        @(posedge clk); #1;
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter SHW, default 5, shift-amount width (log2 XLEN).
REQ-003 SHALL have port clk, input, 1, the only clock, rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports req_valid[1:0], input, 2, one request-valid per requester (0 = EXU, 1 = secondary).
REQ-006 SHALL have ports req_ready[1:0], output, 2, request accepted this cycle when valid&ready.
REQ-007 SHALL have ports req_data0/req_data1, input, XLEN, operand.
REQ-008 SHALL have ports req_shamt0/req_shamt1, input, SHW, shift amount.
REQ-009 SHALL have ports req_l_or_r0/1, input, 1: 1 = left, 0 = right.
REQ-010 SHALL have ports req_a_or_l0/1, input, 1: 1 = arithmetic, 0 = logical; ignored for left shifts.
REQ-011 SHALL have port out_valid, output, 1, result available.
REQ-012 SHALL have port out_ready, input, 1, consumer takes result when valid&ready.
REQ-013 SHALL have port out_data, output, XLEN, shift result.
REQ-014 SHALL have port out_id, output, 1, index of requester that owns out_data.

Function
REQ-015 SHALL run an FSM with states IDLE, RUN, DONE.
REQ-016 IDLE: req_ready asserted to exactly one requester (the grant) only when that requester is valid; both req_ready low in RUN and DONE.
REQ-017 Grant SHALL be round-robin: on both valid, grant the requester not served last; one valid gets the grant regardless of history.
REQ-018 On handshake, SHALL latch data, shamt, l_or_r, a_or_l, id, update the last-served pointer, and go to RUN.
REQ-019 Left shift SHALL fill zeros; logical right fills zeros; arithmetic right fills with operand bit XLEN-1.
REQ-020 shamt = 0 SHALL return the operand unchanged for every mode.
REQ-021 RUN SHALL write the result register and go to DONE (exact cycle count per Configuration).
REQ-022 DONE: out_valid = 1, out_data/out_id stable until out_ready; on out_valid&out_ready go to IDLE.
REQ-023 No new request SHALL be accepted in the cycle the result is consumed; next accept is earliest the following cycle (min issue interval 3 cycles).
REQ-024 Inputs changing while not granted SHALL have no effect; latched operands are immune to input changes after accept.

Reset
REQ-025 rst high at a clock edge SHALL force IDLE, out_valid = 0, out_data = 0, out_id = 0, last-served pointer = 1 (requester 0 wins first tie), req_ready = 0 in that cycle.
REQ-026 Reset mid-RUN or mid-DONE SHALL discard the operation with no out_valid pulse.

Configuration
REQ-027 Macro SHIFT_ARBITER_ITER_EN: when defined, RUN shifts the working register by one bit per cycle using a down-counter of shamt; RUN lasts max(shamt,1) cycles.
REQ-028 Without SHIFT_ARBITER_ITER_EN, RUN SHALL last exactly 1 cycle using a full barrel shift; accept-to-out_valid latency = 2 cycles.
REQ-029 Results SHALL be bit-identical with and without the macro.

Structure
REQ-030 Shared package SHALL hold the FSM state enum (IDLE/RUN/DONE), requester-id constants (REQ_EXU=0, REQ_SEC=1) and the XLEN/SHW defaults.
REQ-031 Shift datapath SHALL be a combinational sub-module shift_core (data, shamt, l_or_r, a_or_l -> result); the arbiter holds all state.

Verification
REQ-032 Req0 only: data 0x0000_00F0, shamt 4, left -> out_data 0x0000_0F00, out_id 0, out_valid 2 cycles after accept (non-ITER).
REQ-033 Req1 arithmetic right: 0x8000_0000, shamt 31 -> 0xFFFF_FFFF; logical right same operand -> 0x0000_0001.
REQ-034 Both valid continuously after reset -> grants alternate 0,1,0,1 over four operations.
REQ-035 out_ready held low 5 cycles in DONE -> out_data/out_id stable, req_ready stays 0, no second accept.
REQ-036 rst asserted during RUN with shamt 20 (ITER build) -> next cycle IDLE, out_valid never asserted, next request served normally.
REQ-037 shamt 0, any mode, data 0xDEAD_BEEF -> 0xDEAD_BEEF; ITER build RUN length exactly 1 cycle.
